onewire_slave: RTL
==================

ONEWIRE_SLAVE -- requirements
Module: onewire_slave

Interface
REQ-001 Parameter CDR, default 50-1: clock divider ratio; the 1 us tick period is CDR+1 clk cycles.
REQ-002 Parameter T_RSTMIN, default 450: minimum low time, in ticks, recognised as a bus reset.
REQ-003 Parameter T_PDLY, default 30: ticks from reset release to presence pulse start.
REQ-004 Parameter T_PRES, default 120: presence pulse low duration, in ticks.
REQ-005 Parameter T_SAMP, default 30: ticks from slot falling edge to receive sample point.
REQ-006 Parameter T_TX0, default 45: ticks the slave holds the line low when sending bit 0.
REQ-007 Port clk, input, 1: single clock, all logic on its rising edge.
REQ-008 Port arst, input, 1: asynchronous, active-high reset.
REQ-009 Port onewire, inout, 1: bus line; the slave drives only 1'b0 or 1'bz, never 1'b1.
REQ-010 Port rx_dat, output, 8: last received byte, LSB first on the wire.
REQ-011 Port rx_vld, output, 1: one-cycle pulse when rx_dat is updated.
REQ-012 Port tx_dat, input, 8: byte to send in master read slots.
REQ-013 Port tx_vld, input, 1: request to load tx_dat.
REQ-014 Port tx_rdy, output, 1: the slave can accept tx_dat.
REQ-015 Port tx_done, output, 1: one-cycle pulse after the 8th transmitted bit completes.
REQ-016 Port rst_det, output, 1: one-cycle pulse on the clk edge where a bus reset is recognised.

Function
REQ-017 The onewire input shall pass through a 2-flop synchroniser; a falling edge is synchroniser output 1 then 0.
REQ-018 The tick divider shall free-run, shall clear on every detected falling edge, and shall assert tick when div == CDR.
REQ-019 A 10-bit low-time counter shall clear on each falling edge, increment on each tick while the synchronised line is low, and saturate at 1023.
REQ-020 FSM states: IDLE, SLOT_RX, SLOT_TX, WAIT_HIGH, PRES_DLY, PRES.
REQ-021 IDLE, falling edge, tx byte not armed: go to SLOT_RX.
REQ-022 IDLE, falling edge, tx byte armed: go to SLOT_TX.
REQ-023 SLOT_RX: when the counter reaches T_SAMP, sample the line into shift bit [bitcnt], increment bitcnt, then go to WAIT_HIGH.
REQ-024 SLOT_TX, current bit 0: assert oe from the falling edge until the counter reaches T_TX0.
REQ-025 SLOT_TX, current bit 1: oe stays 0.
REQ-026 SLOT_TX: when the counter reaches T_TX0, release oe, increment bitcnt, then go to WAIT_HIGH.
REQ-027 WAIT_HIGH: go to IDLE when the synchronised line is high.
REQ-028 Falling edges seen while in any state other than IDLE shall be ignored.
REQ-029 In any state other than PRES and PRES_DLY, if the line is low with counter >= T_RSTMIN, a line-high then sets rst_det, clears bitcnt and the shift register, discards the armed tx byte, releases oe, and moves to PRES_DLY.
REQ-030 PRES_DLY: count T_PDLY ticks, then go to PRES with oe=1.
REQ-031 PRES: hold oe=1 for T_PRES ticks, release, then go to WAIT_HIGH.
REQ-032 After the 8th received bit (bitcnt wraps 7->0), rx_dat shall load the shift register and rx_vld shall pulse one cycle later than the sample.
REQ-033 tx handshake: load occurs when tx_vld && tx_rdy.
REQ-034 tx_rdy shall be 1 only when no byte is armed and bitcnt == 0.
REQ-035 A tx load shall arm the byte; after the 8th tx bit, the byte disarms, tx_done pulses, and tx_rdy returns to 1 in the same cycle.
REQ-036 tx_vld while tx_rdy=0 shall be ignored, with no queuing.
REQ-037 tx_vld arriving in the same cycle as a falling edge shall be loaded, but that slot is handled as SLOT_RX.

Reset
REQ-038 On arst: state=IDLE, oe=0 (line z), bitcnt=0, shift=0, rx_dat=0, rx_vld=0, tx_rdy=1, tx_done=0, rst_det=0, div=0, counter=0, synchroniser flops=1.

Structure
REQ-039 onewire_pkg shall hold the FSM state enum and the default timing constants, shared with onewire_master users.
REQ-040 One sub-module, onewire_sync_edge, shall hold the 2-flop synchroniser and the falling-edge detector.
REQ-041 The tick divider, counter and FSM shall stay in onewire_slave.

Verification (CDR=49, 50 MHz clk, bus model with pull-up)
REQ-042 Master low 480 us, then release -> rst_det pulse; line low from 30 to 150 us after release; rx_vld stays 0.
REQ-043 Master writes 0xA5 (bit 1 = 6 us low, bit 0 = 60 us low, 70 us slots) -> one rx_vld pulse with rx_dat=0xA5.
REQ-044 Load tx_dat=0x3C, then 8 master read slots (1 us low, sample at 15 us) -> master reads 0x3C; tx_done pulses once; tx_rdy rises.
REQ-045 Reset pulse after 4 bits of a 0x3C tx -> byte discarded, tx_rdy=1, next 8 slots received as rx.
REQ-046 arst asserted during PRES -> line released within 1 clk; all outputs at reset values.
REQ-047 tx_vld held while tx_rdy=0 after one load -> exactly one byte transmitted; second request ignored.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire slave (and master-side users of the bus).
// Holds the slave FSM state encoding and the default bus timing constants,
// all timings expressed in 1 us ticks except the clock divider ratio.
package onewire_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SLOT_RX   = 3'd1,
    ST_SLOT_TX   = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_PRES_DLY  = 3'd4,
    ST_PRES      = 3'd5
  } ow_state_e;

  localparam int OW_CDR      = 50 - 1; // clk cycles per tick, minus one
  localparam int OW_T_RSTMIN = 450;    // shortest low time taken as bus reset
  localparam int OW_T_PDLY   = 30;     // reset release to presence start
  localparam int OW_T_PRES   = 120;    // presence pulse length
  localparam int OW_T_SAMP   = 30;     // slot start to receive sample point
  localparam int OW_T_TX0    = 45;     // low time driven for a transmitted 0

  localparam int OW_CNT_W = 10;        // width of the low-time counter

endpackage

// File: rtl/onewire_if.sv
// Byte-level user interface of the 1-Wire slave.
//   tx_dat/tx_vld/tx_rdy : byte to send in master read slots
//   tx_done              : pulse after the 8th transmitted bit
//   rx_dat/rx_vld        : received byte and its one-cycle update pulse
//   rst_det              : pulse when a bus reset is recognised
//   dbg_state            : current slave FSM state, observation only
// Handshake: tx_dat is taken on a rising clk edge where tx_vld and tx_rdy are
// both high; tx_vld while tx_rdy is low is dropped, never queued. rx_vld,
// tx_done and rst_det are single-cycle pulses with no back-pressure.
interface onewire_if;
  import onewire_pkg::*;

  logic [7:0] tx_dat;
  logic       tx_vld;
  logic       tx_rdy;
  logic       tx_done;
  logic [7:0] rx_dat;
  logic       rx_vld;
  logic       rst_det;
  ow_state_e  dbg_state;

  modport slave (
    input  tx_dat, tx_vld,
    output tx_rdy, tx_done, rx_dat, rx_vld, rst_det, dbg_state
  );

  modport master (
    output tx_dat, tx_vld,
    input  tx_rdy, tx_done, rx_dat, rx_vld, rst_det, dbg_state
  );
endinterface

// File: rtl/onewire_sync_edge.sv
// Two-flop synchroniser for the raw 1-Wire line plus falling-edge detector.
//   clk, arst : clock, asynchronous active-high reset (flops reset to 1 = idle bus)
//   line_i    : raw bus level
//   line_o    : synchronised bus level
//   fall_o    : high for one cycle when line_o goes 1 -> 0
module onewire_sync_edge (
  input  logic clk,
  input  logic arst,
  input  logic line_i,
  output logic line_o,
  output logic fall_o
);
  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= line_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign line_o = s2_q;
  assign fall_o = prev_q & ~s2_q;
endmodule

// File: rtl/onewire_slave.sv
// 1-Wire bus slave: receives bytes in master write slots, sends an armed byte
// in master read slots, detects bus resets and answers with a presence pulse.
//   clk, arst : clock, asynchronous active-high reset
//   onewire   : open-drain bus line (driven only 0 or z)
//   bus       : byte handshake interface (slave modport)
module onewire_slave
  import onewire_pkg::*;
#(
  parameter int CDR      = OW_CDR,
  parameter int T_RSTMIN = OW_T_RSTMIN,
  parameter int T_PDLY   = OW_T_PDLY,
  parameter int T_PRES   = OW_T_PRES,
  parameter int T_SAMP   = OW_T_SAMP,
  parameter int T_TX0    = OW_T_TX0
) (
  input  logic        clk,
  input  logic        arst,
  inout  wire         onewire,
  onewire_if.slave    bus
);
  localparam logic [OW_CNT_W-1:0] CNT_MAX = '1;

  logic line, fall, tick, in_slot, bus_rst;

  ow_state_e            state_q, state_d;
  logic [15:0]          div_q, div_d;
  logic [OW_CNT_W-1:0]  cnt_q, cnt_d;
  logic [OW_CNT_W-1:0]  ptmr_q, ptmr_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 armed_q, armed_d;
  logic                 oe_q, oe_d;
  logic                 rx_wrap_q, rx_wrap_d;
  logic                 tx_done_q, tx_done_d;
  logic                 rst_det_q, rst_det_d;
  logic [7:0]           rx_dat_q;
  logic                 rx_vld_q;

  onewire_sync_edge u_sync (
    .clk    (clk),
    .arst   (arst),
    .line_i (onewire),
    .line_o (line),
    .fall_o (fall)
  );

  assign onewire = oe_q ? 1'b0 : 1'bz;
  assign tick    = (div_q == 16'(CDR));
  assign in_slot = (state_q == ST_SLOT_RX) || (state_q == ST_SLOT_TX);
  // A long low followed by a high is a bus reset, except while we are the ones
  // generating the presence sequence.
  assign bus_rst = line && (cnt_q >= OW_CNT_W'(T_RSTMIN)) &&
                   (state_q != ST_PRES) && (state_q != ST_PRES_DLY);

  // Divider restarts on each falling edge so ticks are aligned to the slot.
  // Inside a slot the counter keeps running after the master releases the
  // line, so it measures time since the falling edge; elsewhere it measures
  // only low time.
  always_comb begin
    div_d = div_q + 16'd1;
    if (fall || tick) div_d = '0;
    cnt_d = cnt_q;
    if (fall) cnt_d = '0;
    else if (tick && (!line || in_slot) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptmr_d    = ptmr_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    tx_byte_d = tx_byte_q;
    armed_d   = armed_q;
    oe_d      = oe_q;
    rx_wrap_d = 1'b0;
    tx_done_d = 1'b0;
    rst_det_d = 1'b0;

    if (bus.tx_vld && bus.tx_rdy) begin
      armed_d   = 1'b1;
      tx_byte_d = bus.tx_dat;
    end

    case (state_q)
      ST_IDLE: begin
        // armed_q (not armed_d): a byte loaded on this very edge waits a slot.
        if (fall) begin
          if (armed_q) begin
            state_d = ST_SLOT_TX;
            oe_d    = ~tx_byte_q[bitcnt_q];
          end else begin
            state_d = ST_SLOT_RX;
          end
        end
      end
      ST_SLOT_RX: begin
        if (cnt_q == OW_CNT_W'(T_SAMP)) begin
          shift_d[bitcnt_q] = line;
          bitcnt_d          = bitcnt_q + 3'd1;
          rx_wrap_d         = (bitcnt_q == 3'd7);
          state_d           = ST_WAIT_HIGH;
        end
      end
      ST_SLOT_TX: begin
        if (cnt_q == OW_CNT_W'(T_TX0)) begin
          oe_d     = 1'b0;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            armed_d   = 1'b0;
            tx_done_d = 1'b1;
          end
          state_d = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (line) state_d = ST_IDLE;
      end
      ST_PRES_DLY: begin
        if (tick) begin
          if (ptmr_q == OW_CNT_W'(T_PDLY - 1)) begin
            ptmr_d  = '0;
            oe_d    = 1'b1;
            state_d = ST_PRES;
          end else begin
            ptmr_d = ptmr_q + 1'b1;
          end
        end
      end
      ST_PRES: begin
        if (tick) begin
          if (ptmr_q == OW_CNT_W'(T_PRES - 1)) begin
            ptmr_d  = '0;
            oe_d    = 1'b0;
            state_d = ST_WAIT_HIGH;
          end else begin
            ptmr_d = ptmr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus reset overrides whatever the slot logic decided this cycle.
    if (bus_rst) begin
      rst_det_d = 1'b1;
      bitcnt_d  = '0;
      shift_d   = '0;
      armed_d   = 1'b0;
      oe_d      = 1'b0;
      ptmr_d    = '0;
      rx_wrap_d = 1'b0;
      tx_done_d = 1'b0;
      state_d   = ST_PRES_DLY;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      ptmr_q    <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      tx_byte_q <= '0;
      armed_q   <= 1'b0;
      oe_q      <= 1'b0;
      rx_wrap_q <= 1'b0;
      tx_done_q <= 1'b0;
      rst_det_q <= 1'b0;
      rx_dat_q  <= '0;
      rx_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      ptmr_q    <= ptmr_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      tx_byte_q <= tx_byte_d;
      armed_q   <= armed_d;
      oe_q      <= oe_d;
      rx_wrap_q <= rx_wrap_d;
      tx_done_q <= tx_done_d;
      rst_det_q <= rst_det_d;
      // Byte publishes the cycle after the 8th sample lands in shift_q.
      rx_vld_q  <= rx_wrap_q;
      if (rx_wrap_q) rx_dat_q <= shift_q;
    end
  end

  assign bus.tx_rdy    = !armed_q && (bitcnt_q == 3'd0);
  assign bus.tx_done   = tx_done_q;
  assign bus.rx_dat    = rx_dat_q;
  assign bus.rx_vld    = rx_vld_q;
  assign bus.rst_det   = rst_det_q;
  assign bus.dbg_state = state_q;
endmodule
